// File: rtl/smg_scan_funcmod_pkg.sv
// Shared constants and helpers for the six-digit multiplexed 7-segment driver.
package smg_pkg;

  localparam int NUM_DIG = 6;

  // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] seg_off(input bit act_low);
    return act_low ? 8'hFF : 8'h00;
  endfunction

  function automatic logic [NUM_DIG-1:0] sel_off(input bit act_low);
    return act_low ? {NUM_DIG{1'b1}} : {NUM_DIG{1'b0}};
  endfunction

endpackage

// File: rtl/smg_scan_funcmod_if.sv
// Display word in, board segment/select pins and frame strobe out.
interface smg_scan_funcmod_if;
  import smg_pkg::*;

  logic [4*NUM_DIG-1:0] iData;
  logic [NUM_DIG-1:0]   iDot;
  logic [NUM_DIG-1:0]   iBlank;
  logic                 iLZS;
  logic [7:0]           SMG_Data;
  logic [NUM_DIG-1:0]   Scan_Sig;
  logic                 oFrame;

  modport master (output iData, iDot, iBlank, iLZS, input SMG_Data, Scan_Sig, oFrame);
  modport slave  (input iData, iDot, iBlank, iLZS, output SMG_Data, Scan_Sig, oFrame);

endinterface

// File: rtl/smg_scan_funcmod_hex_decoder.sv
// Nibble plus decimal point to active-high {dp,g..a}; polarity is applied by the parent.
module smg_hex_decoder
  import smg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {dp, hex7(nib)};

endmodule

// File: rtl/smg_scan_funcmod.sv
// Six-digit multiplexed 7-segment scanner with per-frame input latch, ghost blanking,
// per-digit blank, decimal points and leading-zero suppression.
module smg_scan_funcmod
  import smg_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int SCAN_US     = 1000,
  parameter int BLANK_CYC   = 50,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit SEL_ACT_LOW = 1'b1
) (
  input  logic              CLOCK,
  input  logic              RST_n,
  smg_scan_funcmod_if.slave bus
);

  localparam int DIG_CYC = (CLK_FREQ / 1_000_000) * SCAN_US;
  localparam int CNT_W   = $clog2(DIG_CYC);

  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DIG_CYC - 1);
  localparam logic [CNT_W-1:0]   CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [2:0]         DIG_LAST  = 3'(NUM_DIG - 1);
  localparam logic [7:0]         SEG_OFF   = seg_off(SEG_ACT_LOW);
  localparam logic [NUM_DIG-1:0] SEL_OFF   = sel_off(SEL_ACT_LOW);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           dig_q, dig_d;
  logic [4*NUM_DIG-1:0] data_q, data_d;
  logic [NUM_DIG-1:0]   dot_q, dot_d;
  logic [NUM_DIG-1:0]   blank_q, blank_d;
  logic                 lzs_q, lzs_d;
  logic                 frame_q, frame_d;
  logic [7:0]           seg_q, seg_d;
  logic [NUM_DIG-1:0]   sel_q, sel_d;

  logic                 load;
  logic                 zero_run;
  logic [NUM_DIG-1:0]   supp;
  logic [3:0]           nib;
  logic [7:0]           dec_seg;
  logic [7:0]           seg_hi;
  logic [NUM_DIG-1:0]   sel_hi;

  assign nib = data_q[{dig_q, 2'b00} +: 4];

  smg_hex_decoder u_dec (
    .nib (nib),
    .dp  (dot_q[dig_q]),
    .seg (dec_seg)
  );

  // A digit is suppressed while every nibble from it up to the top is zero; digit 0 always shows.
  always_comb begin
    zero_run = lzs_q;
    supp     = '0;
    for (int k = NUM_DIG - 1; k >= 1; k--) begin
      zero_run = zero_run & (data_q[4*k +: 4] == 4'h0);
      supp[k]  = zero_run;
    end
  end

  always_comb begin
    load    = (cnt_q == '0) && (dig_q == '0);
    cnt_d   = cnt_q + 1'b1;
    dig_d   = dig_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      dig_d = (dig_q == DIG_LAST) ? 3'd0 : dig_q + 3'd1;
    end

    data_d  = load ? bus.iData  : data_q;
    dot_d   = load ? bus.iDot   : dot_q;
    blank_d = load ? bus.iBlank : blank_q;
    lzs_d   = load ? bus.iLZS   : lzs_q;
    frame_d = load;

    seg_hi = 8'h00;
    sel_hi = '0;
    if ((cnt_q >= CNT_BLANK) && !blank_q[dig_q] && !(supp[dig_q] && !dot_q[dig_q])) begin
      sel_hi = NUM_DIG'(1) << dig_q;
      seg_hi = supp[dig_q] ? 8'h80 : dec_seg;
    end
    seg_d = SEG_ACT_LOW ? ~seg_hi : seg_hi;
    sel_d = SEL_ACT_LOW ? ~sel_hi : sel_hi;
  end

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      cnt_q   <= '0;
      dig_q   <= '0;
      data_q  <= '0;
      dot_q   <= '0;
      blank_q <= '0;
      lzs_q   <= 1'b0;
      frame_q <= 1'b0;
      seg_q   <= SEG_OFF;
      sel_q   <= SEL_OFF;
    end else begin
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      data_q  <= data_d;
      dot_q   <= dot_d;
      blank_q <= blank_d;
      lzs_q   <= lzs_d;
      frame_q <= frame_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.SMG_Data = seg_q;
  assign bus.Scan_Sig = sel_q;
  assign bus.oFrame   = frame_q;

endmodule

// File: doc/smg_scan_funcmod.md
Name: smg_scan_funcmod

Overview:
- Six-digit multiplexed 7-segment display driver.
- Sits downstream of the PS/2 decoder in keyboard test tops and accepts a 24-bit word of six hex nibbles.
- Latches the word once per frame, decodes each nibble to segments, and time-multiplexes the digit selects, with ghost blanking, per-digit blank, decimal points and optional leading-zero suppression.
- Outputs drive the board's SMG_Data and Scan_Sig pins directly.

Parameters:
- CLK_FREQ, 50_000_000, CLOCK frequency in Hz.
- SCAN_US, 1000, on-time per digit in microseconds. DIG_CYC = (CLK_FREQ/1_000_000)*SCAN_US, and must be ≥ 4.
- BLANK_CYC, 50, cycles at the start of each digit slot with all selects inactive. Must be < DIG_CYC.
- SEG_ACT_LOW, 1, 1 means segment lines are active-low (common anode).
- SEL_ACT_LOW, 1, 1 means digit-select lines are active-low.

Ports:
- CLOCK  in  1  system clock.
- RST_n  in  1  asynchronous active-low reset.
- iData  in  24  six nibbles; digit k = iData[4k+3:4k]; digit 0 is rightmost.
- iDot  in  6  decimal point enable per digit.
- iBlank  in  6  force digit k fully dark.
- iLZS  in  1  leading-zero suppression enable.
- SMG_Data  out  8  segments {dp,g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW.
- Scan_Sig  out  6  digit selects, bit k = digit k, polarity per SEL_ACT_LOW.
- oFrame  out  1  one-cycle pulse when the shadow register loads.

Behaviour:
- Clock and reset: one clock, CLOCK. RST_n is asynchronous and active-low.
- Reset values:
  - cnt=0, dig=0, shadow registers (data/dot/blank/lzs)=0, oFrame=0.
  - SMG_Data = all segments off (8'hFF when SEG_ACT_LOW=1).
  - Scan_Sig = all inactive (6'h3F when SEL_ACT_LOW=1).
- Counters:
  - cnt runs 0..DIG_CYC-1.
  - At cnt==DIG_CYC-1: cnt→0 and dig→dig+1, wrapping 5→0.
  - Scan order is 0,1,2,3,4,5,0,…
  - Frame period = 6*DIG_CYC.
- Frame latch:
  - On every cycle where cnt==0 and dig==0, the shadow registers capture iData/iDot/iBlank/iLZS.
  - This includes the first cycle after reset release.
  - oFrame=1 on the following cycle only.
  - Input changes mid-frame never reach the display until the next frame (no tearing).
- Leading-zero suppression (evaluated on shadow values):
  - Digit k (k=5..1) is suppressed when lzs=1 and nibbles k..5 are all 0.
  - Digit 0 is never suppressed.
- Per-slot selection, evaluated from (cnt,dig) and registered, so outputs lag state by exactly 1 cycle:
  - cnt < BLANK_CYC → all selects inactive, segments off.
  - Else if blank[dig] → all inactive, segments off.
  - Else if digit suppressed and dot[dig]=0 → all inactive, segments off.
  - Else if suppressed and dot[dig]=1 → only select dig active, only dp lit.
  - Else → only select dig active, segments = hex LUT(nibble) with dp = dot[dig].
- Hex LUT, active-high {dp=0,g..a}:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
  - Output inverted when SEG_ACT_LOW=1.
- Invariant: at most one select is ever active in any cycle.
- Reset mid-frame: outputs go to the off state immediately (asynchronously). Scanning restarts at dig 0 with a fresh latch on the first clock after release.

Decomposition:
- Package smg_pkg holds:
  - the 16-entry segment LUT as a function;
  - the NUM_DIG=6 constant;
  - the SEG_OFF/SEL_OFF helpers derived from the polarity parameters.
- One combinational sub-module, smg_hex_decoder: nibble + dp in, 8-bit active-high segments out. Polarity is applied in the parent.

Test Plan:
All scenarios use CLK_FREQ=1_000_000, SCAN_US=8 (DIG_CYC=8), BLANK_CYC=2, active-low.
1. Reset, then iData=24'h012345, iDot=0, iBlank=0, iLZS=0.
   - Digit 0 slot, cycles 3..8 after release: Scan_Sig=6'h3E, SMG_Data=8'h92 ("5").
   - Digit 5 slot: Scan_Sig=6'h1F, SMG_Data=8'hC0 ("0").
   - First 2 cycles of every slot: Scan_Sig=6'h3F.
2. iData=24'h00000A, iLZS=1, iDot=6'b000100.
   - Digits 5,4,3,1 dark: Scan_Sig=6'h3F for the whole slot.
   - Digit 2: Scan_Sig=6'h3B, SMG_Data=8'h7F (dp only).
   - Digit 0: SMG_Data=8'h88 ("A").
3. iData changes from 24'h111111 to 24'h222222 while dig=3.
   - Digits 3–5 still show 8'hF9 ("1").
   - The next frame shows 8'hA4 ("2") on all digits.
   - oFrame pulses once per 48 cycles.
4. iBlank=6'b101010 with iData=24'hFFFFFF.
   - Odd digits never selected.
   - Even digits show 8'h8E ("F").
5. Assert RST_n low mid-slot of digit 4.
   - Same cycle: SMG_Data=8'hFF, Scan_Sig=6'h3F.
   - After release, the first active slot is digit 0 and oFrame pulses at cycle 2.
6. Over 1000 random frames, assert onehot0(~Scan_Sig) every cycle, and each digit is active exactly DIG_CYC-BLANK_CYC=6 cycles per frame when not blanked.
